uart_receiver_parity: RTL and testbench

UART_RECEIVER_PARITY -- requirements
Module: uart_receiver_parity

---
 rtl/uart_receiver_parity.sv | 128 ++++++++++++
 tb/tb_uart_receiver_parity.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver_parity.sv
// 8-bit UART receiver with even parity and stop-bit checking.
// Frame: start(0), 8 data bits LSB first, parity = ^data, stop(1).
module uart_receiver_parity #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state, state_nxt;
  logic        rx_meta, rxs, rxs_d;
  logic [15:0] sample_cnt, sample_cnt_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shift_reg, shift_nxt;
  logic        par_bit, par_bit_nxt;
  logic        done;

  // rxs_d lags rxs so IDLE can require a real 1->0 edge, never a steady low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
    end else begin
      state      <= state_nxt;
      sample_cnt <= sample_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift_reg  <= shift_nxt;
      par_bit    <= par_bit_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    sample_cnt_nxt = sample_cnt + 16'd1;
    bit_cnt_nxt    = bit_cnt;
    shift_nxt      = shift_reg;
    par_bit_nxt    = par_bit;
    done           = 1'b0;
    case (state)
      IDLE: begin
        sample_cnt_nxt = '0;
        if (rxs_d && !rxs) state_nxt = START;
      end
      START: begin
        if (sample_cnt == HALF_LAST) begin
          sample_cnt_nxt = '0;
          bit_cnt_nxt    = '0;
          state_nxt      = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample_cnt == FULL_LAST) begin
          sample_cnt_nxt = '0;
          shift_nxt      = {rxs, shift_reg[7:1]};
          bit_cnt_nxt    = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (sample_cnt == FULL_LAST) begin
          sample_cnt_nxt = '0;
          par_bit_nxt    = rxs;
          state_nxt      = STOP;
        end
      end
      STOP: begin
        if (sample_cnt == FULL_LAST) begin
          sample_cnt_nxt = '0;
          done           = 1'b1;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Results are captured on the stop-sample edge, so valid appears the cycle after it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid      <= 1'b0;
      dout       <= 8'h00;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= done;
      if (done) begin
        dout       <= shift_reg;
        parity_err <= par_bit ^ (^shift_reg);
        frame_err  <= ~rxs;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver_parity.sv
// Directed testbench for uart_receiver_parity at CLKS_PER_BIT=16.
module tb_uart_receiver_parity;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] dout;
  logic       valid, parity_err, frame_err, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vcount = 0;
  logic [7:0] cap_dout [0:15];
  logic       cap_perr [0:15];
  logic       cap_ferr [0:15];
  int         cap_cyc  [0:15];

  uart_receiver_parity #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .dout(dout), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle valid is high counts as a pulse, so a stretched pulse shows up as extra frames
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (vcount < 16) begin
        cap_dout[vcount] <= dout;
        cap_perr[vcount] <= parity_err;
        cap_ferr[vcount] <= frame_err;
        cap_cyc[vcount]  <= cyc;
      end
      vcount <= vcount + 1;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    wait_cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic check_frame(input string name, input int idx, input logic [7:0] exp_d,
                             input logic exp_p, input logic exp_f);
    total++;
    if (vcount <= idx) begin
      bad++;
      $display("[TB] FAIL %s_count: got %0d pulses, expected more than %0d", name, vcount, idx);
    end else begin
      if (cap_dout[idx] !== exp_d) begin
        bad++;
        $display("[TB] FAIL %s_dout: got %h expected %h", name, cap_dout[idx], exp_d);
      end
      total++;
      if (cap_perr[idx] !== exp_p) begin
        bad++;
        $display("[TB] FAIL %s_parity_err: got %b expected %b", name, cap_perr[idx], exp_p);
      end
      total++;
      if (cap_ferr[idx] !== exp_f) begin
        bad++;
        $display("[TB] FAIL %s_frame_err: got %b expected %b", name, cap_ferr[idx], exp_f);
      end
    end
  endtask

  task automatic check_count(input string name, input int exp_n);
    total++;
    if (vcount !== exp_n) begin
      bad++;
      $display("[TB] FAIL %s_pulses: got %0d expected %0d", name, vcount, exp_n);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (dout !== 8'h00 || valid !== 1'b0 || parity_err !== 1'b0 ||
        frame_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s: got dout=%h valid=%b perr=%b ferr=%b busy=%b expected 00/0/0/0/0",
               name, dout, valid, parity_err, frame_err, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rxd = 1'b1;
    wait_cycles(3);
    check_idle_outputs("reset_values");
    rst = 1'b1;
    wait_cycles(5);
  endtask

  task automatic test_good_byte();
    int base, t0, lat;
    base = vcount;
    t0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_cycles(20);
    check_count("good", base + 1);
    check_frame("good", base, 8'hA5, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL good_busy: got %b expected 0", busy);
    end
    lat = cap_cyc[base] - t0;
    total++;
    if (lat < 170 || lat > 172) begin
      bad++;
      $display("[TB] FAIL good_latency: got %0d expected 171 +/-1", lat);
    end
    wait_cycles(50);
    total++;
    if (dout !== 8'hA5 || valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL good_hold: got dout=%h valid=%b expected a5/0", dout, valid);
    end
  endtask

  task automatic test_parity_error();
    int base;
    base = vcount;
    send_frame(8'h01, 1'b0, 1'b1);
    wait_cycles(20);
    check_count("parity", base + 1);
    check_frame("parity", base, 8'h01, 1'b1, 1'b0);
  endtask

  task automatic test_frame_error();
    int base;
    base = vcount;
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_cycles(40);
    check_count("frame_low_hold", base + 1);
    rxd = 1'b1;
    wait_cycles(30);
    check_count("frame", base + 1);
    check_frame("frame", base, 8'h3C, 1'b0, 1'b1);
  endtask

  task automatic test_both_errors();
    int base;
    base = vcount;
    send_frame(8'h07, 1'b0, 1'b0);
    rxd = 1'b1;
    wait_cycles(30);
    check_count("both", base + 1);
    check_frame("both", base, 8'h07, 1'b1, 1'b1);
  endtask

  task automatic test_glitch();
    int base;
    base = vcount;
    rxd = 1'b0;
    wait_cycles(4);
    rxd = 1'b1;
    wait_cycles(1);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL glitch_busy_high: got %b expected 1", busy);
    end
    wait_cycles(11);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL glitch_busy_low: got %b expected 0", busy);
    end
    wait_cycles(30);
    check_count("glitch", base);
  endtask

  task automatic test_back_to_back();
    int base;
    base = vcount;
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1);
    wait_cycles(20);
    check_count("b2b", base + 2);
    check_frame("b2b_first", base, 8'hFF, 1'b0, 1'b0);
    check_frame("b2b_second", base + 1, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int base;
    base = vcount;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b0;
    wait_cycles(2);
    check_idle_outputs("midreset_values");
    wait_cycles(5);
    rst = 1'b1;
    wait_cycles(200);
    check_count("midreset", base);
    send_frame(8'h5A, 1'b0, 1'b1);
    wait_cycles(20);
    check_count("after_reset", base + 1);
    check_frame("after_reset", base, 8'h5A, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_good_byte();
    test_parity_error();
    test_frame_error();
    test_both_errors();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
